// File: rtl/video_timing_gen.sv
// Raster timing generator: req_x/req_y registered counters with a combinational req_valid, and sync/de/pulse outputs
// aligned PIX_LAT cycles later. No backpressure; en=0 clears counters and the delay line. Optional VTG_FRAME_CNT_EN adds frame_count.
module video_timing_gen #(
  parameter int CNT_W     = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PIX_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             req_valid,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
    $error("video_timing_gen: PIX_LAT must be 0..7");
  end

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   ext_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } tim_t;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam tim_t IDLE   = '0;

  cnt_t x, y;
  ext_t xe, ye;
  tim_t raw, dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (!en) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      if (y == V_LAST) y <= '0;
      else             y <= y + cnt_t'(1);
    end else begin
      x <= x + cnt_t'(1);
    end
  end

  // One extra bit so sync-window bounds equal to 2^CNT_W still compare correctly.
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  always_comb begin
    raw    = IDLE;
    raw.de = (xe < ext_t'(H_ACTIVE)) && (ye < ext_t'(V_ACTIVE));
    raw.hs = (xe >= ext_t'(HS_START)) && (xe < ext_t'(HS_END));
    raw.vs = (ye >= ext_t'(VS_START)) && (ye < ext_t'(VS_END));
    raw.ls = (x == '0);
    raw.fs = (x == '0) && (y == '0);
  end

  assign req_x     = x;
  assign req_y     = y;
  assign req_valid = raw.de;

  if (PIX_LAT == 0) begin : g_nolat
    assign dly = en ? raw : IDLE;
  end else begin : g_lat
    tim_t pipe [PIX_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIX_LAT; i++) pipe[i] <= IDLE;
      end else if (!en) begin
        for (int i = 0; i < PIX_LAT; i++) pipe[i] <= IDLE;
      end else begin
        pipe[0] <= raw;
        for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dly = pipe[PIX_LAT-1];
  end

  // Polarity applied after the delay so idle stages produce the inactive level.
  assign de          = dly.de;
  assign hsync       = dly.hs ~^ HSYNC_POL;
  assign vsync       = dly.vs ~^ VSYNC_POL;
  assign line_start  = dly.ls;
  assign frame_start = dly.fs;

`ifdef VTG_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_count <= '0;
    else if (!en)         frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default timing (PIX_LAT=1), same-cycle inverted hsync (PIX_LAT=0), and a small raster (PIX_LAT=2) for full frames.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_b, en_c;
  logic [9:0] rx_a, ry_a, rx_b, ry_b, rx_c, ry_c;
  logic rv_a, de_a, hs_a, vs_a, ls_a, fs_a;
  logic rv_b, de_b, hs_b, vs_b, ls_b, fs_b;
  logic rv_c, de_c, hs_c, vs_c, ls_c, fs_c;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  video_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en_a), .req_x(rx_a), .req_y(ry_a), .req_valid(rv_a),
    .de(de_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VTG_FRAME_CNT_EN
    , .frame_count(fc_a)
`endif
  );

  video_timing_gen #(.PIX_LAT(0), .HSYNC_POL(1'b0)) u_z (
    .clk(clk), .rst_n(rst_n), .en(en_b), .req_x(rx_b), .req_y(ry_b), .req_valid(rv_b),
    .de(de_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VTG_FRAME_CNT_EN
    , .frame_count(fc_b)
`endif
  );

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_LAT(2)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en_c), .req_x(rx_c), .req_y(ry_c), .req_valid(rv_c),
    .de(de_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VTG_FRAME_CNT_EN
    , .frame_count(fc_c)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  int xerr, hs_n, hs_first, hs_last, de_n, ls_n, fs_n, rv_n, zerr, z_low, hs_err;
  int sfs_n, sfs_first, sfs_last, coinc_err, svs_n, svs_first, sls_n, sde_n;
  logic first_fs, ez;

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    xerr = 0; hs_n = 0; hs_first = -1; hs_last = -1; de_n = 0; ls_n = 0; fs_n = 0;
    rv_n = 0; zerr = 0; z_low = 0; hs_err = 0; first_fs = 1'b0;
    sfs_n = 0; sfs_first = -1; sfs_last = -1; coinc_err = 0;
    svs_n = 0; svs_first = -1; sls_n = 0; sde_n = 0;

    // During reset
    #3;
    chk1("rst_de", de_a, 1'b0);
    chk1("rst_hsync", hs_a, 1'b0);
    chk1("rst_vsync", vs_a, 1'b0);
    chk1("rst_line_start", ls_a, 1'b0);
    chk1("rst_frame_start", fs_a, 1'b0);
    chk("rst_req_x", 32'(rx_a), 0);
    chk("rst_req_y", 32'(ry_a), 0);
    chk1("rst_req_valid", rv_a, 1'b1);
    chk1("rst_hsync_neg_idle", hs_b, 1'b1);
    chk1("rst_de_lat0", de_b, 1'b0);
`ifdef VTG_FRAME_CNT_EN
    chk("rst_frame_count", 32'(fc_c), 0);
`endif
    #20 rst_n = 1'b1;
    tick; tick;
    chk1("idle_de", de_a, 1'b0);
    chk1("idle_hsync", hs_a, 1'b0);
    chk1("idle_frame_start", fs_a, 1'b0);
    chk("idle_req_x", 32'(rx_a), 0);
    chk1("idle_frame_start_lat0", fs_b, 1'b0);

    // One full default line
    en_a = 1'b1; en_b = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      tick;
      if (rx_a != 10'(k % 800) || ry_a != 10'(k / 800)) xerr++;
      if (k == 1) first_fs = fs_a;
      if (hs_a) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(rx_a);
        hs_last = int'(rx_a);
      end
      if (de_a) de_n++;
      if (ls_a) ls_n++;
      if (fs_a) fs_n++;
      if (rv_a) rv_n++;
      ez = !((k % 800) >= 656 && (k % 800) < 752);
      if (hs_b !== ez) zerr++;
      if (!hs_b) z_low++;
    end
    chk("x_y_sequence_errors", 32'(xerr), 0);
    chk1("first_frame_start", first_fs, 1'b1);
    chk("hsync_cycles", 32'(hs_n), 96);
    chk("hsync_first_x", 32'(hs_first), 657);
    chk("hsync_last_x", 32'(hs_last), 752);
    chk("de_cycles_line", 32'(de_n), 640);
    chk("line_start_pulses", 32'(ls_n), 1);
    chk("frame_start_pulses", 32'(fs_n), 1);
    chk("req_valid_cycles", 32'(rv_n), 640);
    chk("lat0_hsync_errors", 32'(zerr), 0);
    chk("lat0_hsync_low_cycles", 32'(z_low), 96);

    tick;
    chk1("line2_line_start", ls_a, 1'b1);
    chk1("line2_frame_start", fs_a, 1'b0);
    chk("line2_req_y", 32'(ry_a), 1);

    // Run to x=300, y=2 then drop en for 5 cycles
    repeat (1099) tick;
    chk("drop_req_x", 32'(rx_a), 300);
    chk("drop_req_y", 32'(ry_a), 2);
    en_a = 1'b0;
    tick;
    chk("off_req_x", 32'(rx_a), 0);
    chk("off_req_y", 32'(ry_a), 0);
    chk1("off_de", de_a, 1'b0);
    chk1("off_line_start", ls_a, 1'b0);
    repeat (4) tick;
    en_a = 1'b1;
    #1;
    chk("restart_req_x", 32'(rx_a), 0);
    chk("restart_req_y", 32'(ry_a), 0);
    chk1("restart_fs_not_yet", fs_a, 1'b0);
    tick;
    chk1("restart_frame_start", fs_a, 1'b1);
    chk1("restart_line_start", ls_a, 1'b1);
    for (int k = 2; k <= 700; k++) begin
      tick;
      if (hs_a && k < 657) hs_err++;
    end
    chk("restart_partial_hsync", 32'(hs_err), 0);
    chk("mid_hsync_req_x", 32'(rx_a), 700);
    chk1("mid_hsync_active", hs_a, 1'b1);

    // Asynchronous reset in the middle of hsync
    #1 rst_n = 1'b0;
    #1;
    chk1("async_rst_hsync", hs_a, 1'b0);
    chk1("async_rst_de", de_a, 1'b0);
    chk("async_rst_req_x", 32'(rx_a), 0);
    chk1("async_rst_hsync_neg", hs_b, 1'b1);
    chk("async_rst_req_x_lat0", 32'(rx_b), 0);
    en_a = 1'b0; en_b = 1'b0;
    #3 rst_n = 1'b1;
    tick;

    // Small raster: 16x11 = 176 cycles per frame, PIX_LAT=2
    en_c = 1'b1;
    for (int k = 1; k <= 530; k++) begin
      tick;
      if (k == 1) chk1("small_fs_tick1", fs_c, 1'b0);
      if (k == 176) begin
        chk("small_wrap_x", 32'(rx_c), 0);
        chk("small_wrap_y", 32'(ry_c), 0);
      end
      if (fs_c) begin
        sfs_n++;
        if (sfs_first < 0) sfs_first = k;
        sfs_last = k;
        if (!ls_c) coinc_err++;
      end
      if (k <= 176) begin
        if (vs_c) begin
          svs_n++;
          if (svs_first < 0) svs_first = k;
        end
        if (ls_c) sls_n++;
        if (de_c) sde_n++;
      end
`ifdef VTG_FRAME_CNT_EN
      if (k == 530) chk("frame_count_3_frames", 32'(fc_c), 3);
`endif
    end
    chk("small_fs_pulses", 32'(sfs_n), 4);
    chk("small_fs_first", 32'(sfs_first), 2);
    chk("small_fs_last", 32'(sfs_last), 530);
    chk("small_fs_without_ls", 32'(coinc_err), 0);
    chk("small_vsync_cycles", 32'(svs_n), 32);
    chk("small_vsync_first", 32'(svs_first), 114);
    chk("small_line_starts", 32'(sls_n), 11);
    chk("small_de_cycles", 32'(sde_n), 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
